// File: rtl/dmem_arbiter_pkg.sv
// ============================================================================
// Module : dmem_arbiter_pkg
// Brief  : Shared types and constants for the data-memory port arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package dmem_arbiter_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;

    localparam int PORT_CORE = 0;
    localparam int PORT_DMA  = 1;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } dmem_arb_state_e;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic                  wen;
        logic [3:0]            be;
    } dmem_req_t;

    function automatic logic [1:0] port_onehot(input logic port);
        return port ? 2'b10 : 2'b01;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_arb_rr.sv
// ============================================================================
// Module : dmem_arb_rr
// Brief  : Two-way round-robin grant with a port-1 override for lock bursts.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_arb_rr
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0] valid_i,
    input  logic       rr_ptr_i,
    input  logic       force_port1_i,
    output logic       grant_o
);

    // With both or neither requesting, the pointer decides.
    always_comb begin
        grant_o = rr_ptr_i;
        if (force_port1_i) begin
            grant_o = 1'(PORT_DMA);
        end else if (valid_i == 2'b01) begin
            grant_o = 1'(PORT_CORE);
        end else if (valid_i == 2'b10) begin
            grant_o = 1'(PORT_DMA);
        end
    end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module : dmem_arbiter
// Brief  : Shares one data-memory port between core (0) and DMA (1) with
//          round-robin arbitration, bounded DMA lock bursts and a registered
//          1-cycle response. Optional counters: DMEM_ARB_PERF_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int MAX_LOCK   = 8,
    parameter int ADDR_WIDTH = dmem_arbiter_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = dmem_arbiter_pkg::DATA_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 req_valid,
    output logic [1:0]                 req_ready,
    input  logic [1:0][ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0][DATA_WIDTH-1:0] req_wdata,
    input  logic [1:0]                 req_wen,
    input  logic [1:0][3:0]            req_be,
    input  logic                       dma_lock,
    output logic [1:0]                 rsp_valid,
    output logic [DATA_WIDTH-1:0]      rsp_rdata,
    output logic [ADDR_WIDTH-1:0]      mem_addr,
    output logic [DATA_WIDTH-1:0]      mem_wdata,
    output logic                       mem_wen,
    output logic [3:0]                 mem_byte_en,
    input  logic [DATA_WIDTH-1:0]      mem_rdata,
`ifdef DMEM_ARB_PERF_EN
    output logic [31:0]                perf_conflict,
    output logic [31:0]                perf_lock_block,
`endif
    input  logic                       mem_ready
);

    localparam logic [7:0] c_MAX_LOCK = 8'(MAX_LOCK);

    dmem_arb_state_e        state_q, state_d;
    logic                   rr_ptr_q, rr_ptr_d;
    logic [7:0]             lock_cnt_q, lock_cnt_d;
    logic [1:0]             rsp_valid_q;
    logic [DATA_WIDTH-1:0]  rsp_rdata_q;

    logic                   w_grant;
    logic                   w_accept;

    dmem_arb_rr u_rr (
        .valid_i       (req_valid),
        .rr_ptr_i      (rr_ptr_q),
        .force_port1_i (state_q == LOCKED),
        .grant_o       (w_grant)
    );

    assign w_accept    = req_valid[w_grant] & mem_ready;
    assign req_ready   = mem_ready ? port_onehot(w_grant) : 2'b00;

    assign mem_addr    = req_addr[w_grant];
    assign mem_wdata   = req_wdata[w_grant];
    assign mem_byte_en = req_be[w_grant];
    assign mem_wen     = w_accept & req_wen[w_grant];

    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_cnt_d = lock_cnt_q;
        case (state_q)
            ARB: begin
                if (w_accept) begin
                    rr_ptr_d = ~w_grant;
                    if ((w_grant == 1'(PORT_DMA)) && dma_lock && (MAX_LOCK > 1)) begin
                        state_d    = LOCKED;
                        lock_cnt_d = 8'd1;
                    end
                end
            end
            LOCKED: begin
                // Every exit from a lock hands the next contested slot to the core.
                if (!req_valid[PORT_DMA]) begin
                    state_d    = ARB;
                    rr_ptr_d   = 1'b0;
                    lock_cnt_d = 8'd0;
                end else if (w_accept) begin
                    if (dma_lock && ((lock_cnt_q + 8'd1) != c_MAX_LOCK)) begin
                        lock_cnt_d = lock_cnt_q + 8'd1;
                    end else begin
                        state_d    = ARB;
                        rr_ptr_d   = 1'b0;
                        lock_cnt_d = 8'd0;
                    end
                end
            end
            default: begin
                state_d    = ARB;
                rr_ptr_d   = 1'b0;
                lock_cnt_d = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB;
            rr_ptr_q    <= 1'b0;
            lock_cnt_q  <= 8'd0;
            rsp_valid_q <= 2'b00;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            lock_cnt_q  <= lock_cnt_d;
            rsp_valid_q <= w_accept ? port_onehot(w_grant) : 2'b00;
            rsp_rdata_q <= (w_accept && !req_wen[w_grant]) ? mem_rdata : '0;
        end
    end

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] perf_conflict_q;
    logic [31:0] perf_lock_block_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_conflict_q   <= 32'd0;
            perf_lock_block_q <= 32'd0;
        end else begin
            if ((&req_valid) && (perf_conflict_q != 32'hFFFF_FFFF)) begin
                perf_conflict_q <= perf_conflict_q + 32'd1;
            end
            if ((state_q == LOCKED) && req_valid[PORT_CORE] &&
                (perf_lock_block_q != 32'hFFFF_FFFF)) begin
                perf_lock_block_q <= perf_lock_block_q + 32'd1;
            end
        end
    end

    assign perf_conflict   = perf_conflict_q;
    assign perf_lock_block = perf_lock_block_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module : tb_dmem_arbiter
// Brief  : Scoreboard bench for dmem_arbiter with a behavioural memory.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

    localparam int c_MAX_LOCK = 4;
    localparam int c_WORDS    = 64;

    logic              clk;
    logic              rst;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0][31:0]  req_addr;
    logic [1:0][31:0]  req_wdata;
    logic [1:0]        req_wen;
    logic [1:0][3:0]   req_be;
    logic              dma_lock;
    logic [1:0]        rsp_valid;
    logic [31:0]       rsp_rdata;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_wen;
    logic [3:0]        mem_byte_en;
    logic [31:0]       mem_rdata;
    logic              mem_ready;

    logic [31:0] mem    [c_WORDS];
    logic [31:0] shadow [c_WORDS];

    typedef struct {
        logic [1:0]  vld;
        logic [31:0] data;
    } rsp_t;
    rsp_t sb_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    logic       m_rr;
    logic       m_locked;
    int         m_cnt;

    dmem_arbiter #(
        .MAX_LOCK   (c_MAX_LOCK),
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_wen     (req_wen),
        .req_be      (req_be),
        .dma_lock    (dma_lock),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wen     (mem_wen),
        .mem_byte_en (mem_byte_en),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Out-of-range addresses read as zero and ignore writes.
    assign mem_rdata = (mem_addr < 32'(c_WORDS * 4)) ? mem[mem_addr[7:2]] : 32'd0;

    always @(posedge clk) begin
        if (mem_wen && (mem_addr < 32'(c_WORDS * 4))) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_byte_en[b]) mem[mem_addr[7:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_p(input int p, input logic v, input logic w,
                         input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        req_valid[p] = v;
        req_wen[p]   = w;
        req_addr[p]  = a;
        req_wdata[p] = d;
        req_be[p]    = be;
    endtask

    task automatic idle();
        req_valid = 2'b00;
        req_wen   = 2'b00;
        dma_lock  = 1'b0;
        mem_ready = 1'b1;
    endtask

    // One clock: predict the handshake from the spec model, then check the response.
    task automatic cyc();
        logic        g;
        logic        acc;
        logic [31:0] a;
        rsp_t        e;
        #2;
        if (!rst) begin
            if (m_locked)                g = 1'b1;
            else if (req_valid == 2'b01) g = 1'b0;
            else if (req_valid == 2'b10) g = 1'b1;
            else                         g = m_rr;
            acc = req_valid[g] & mem_ready;
            chk("req_ready", {30'd0, req_ready}, mem_ready ? (g ? 32'd2 : 32'd1) : 32'd0);
            chk("mem_wen", {31'd0, mem_wen}, {31'd0, acc & req_wen[g]});
            if (acc) begin
                a = req_addr[g];
                chk("mem_addr", mem_addr, a);
                e.vld  = g ? 2'b10 : 2'b01;
                e.data = 32'd0;
                if (a < 32'(c_WORDS * 4)) begin
                    if (req_wen[g]) begin
                        chk("mem_wdata", mem_wdata, req_wdata[g]);
                        chk("mem_be", {28'd0, mem_byte_en}, {28'd0, req_be[g]});
                        for (int b = 0; b < 4; b++) begin
                            if (req_be[g][b]) shadow[a[7:2]][b*8 +: 8] = req_wdata[g][b*8 +: 8];
                        end
                    end else begin
                        e.data = shadow[a[7:2]];
                    end
                end
                sb_q.push_back(e);
            end
            if (m_locked) begin
                if (!req_valid[1]) begin
                    m_locked = 1'b0; m_rr = 1'b0; m_cnt = 0;
                end else if (acc) begin
                    if (dma_lock && (m_cnt + 1 < c_MAX_LOCK)) begin
                        m_cnt++;
                    end else begin
                        m_locked = 1'b0; m_rr = 1'b0; m_cnt = 0;
                    end
                end
            end else if (acc) begin
                m_rr = ~g;
                if (g && dma_lock && (c_MAX_LOCK > 1)) begin
                    m_locked = 1'b1; m_cnt = 1;
                end
            end
        end
        @(posedge clk);
        #1;
        if (rst) begin
            sb_q.delete();
            m_rr = 1'b0; m_locked = 1'b0; m_cnt = 0;
            chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
            chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        end else if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("rsp_valid", {30'd0, rsp_valid}, {30'd0, e.vld});
            chk("rsp_rdata", rsp_rdata, e.data);
        end else begin
            chk("rsp_idle", {30'd0, rsp_valid}, 32'd0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < c_WORDS; i++) begin
            mem[i]    = (i * 32'h0101_0101) ^ 32'h5A5A_0000;
            shadow[i] = (i * 32'h0101_0101) ^ 32'h5A5A_0000;
        end
        mem[4] = 32'hDEAD_BEEF; shadow[4] = 32'hDEAD_BEEF;
        m_rr = 1'b0; m_locked = 1'b0; m_cnt = 0;
        req_addr = '0; req_wdata = '0; req_be = '0;
        idle();
        rst = 1'b1;
        @(posedge clk); #1;
        cyc();
        cyc();
        rst = 1'b0;

        // Single read
        set_p(0, 1'b1, 1'b0, 32'h10, 32'd0, 4'hF);
        #1 chk("single_rdy", {30'd0, req_ready}, 32'd1);
        cyc();
        idle();
        chk("single_data", rsp_rdata, 32'hDEAD_BEEF);
        cyc();

        // Contention after reset: 0,1,0,1
        do_reset();
        set_p(0, 1'b1, 1'b0, 32'h20, 32'd0, 4'hF);
        set_p(1, 1'b1, 1'b0, 32'h24, 32'd0, 4'hF);
        for (int i = 0; i < 4; i++) begin
            #1 chk("contend_rdy", {30'd0, req_ready}, (i % 2) ? 32'd2 : 32'd1);
            cyc();
        end
        idle();
        cyc();

        // Stall with a pending core write
        set_p(0, 1'b1, 1'b1, 32'h30, 32'hCAFE_F00D, 4'hF);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall_rdy", {30'd0, req_ready}, 32'd0);
            chk("stall_wen", {31'd0, mem_wen}, 32'd0);
            cyc();
        end
        mem_ready = 1'b1;
        cyc();
        chk("stall_rsp", {30'd0, rsp_valid}, 32'd1);
        set_p(0, 1'b1, 1'b0, 32'h30, 32'd0, 4'hF);
        cyc();
        chk("stall_readback", rsp_rdata, 32'hCAFE_F00D);
        idle();

        // Lock burst, forced release, resume, then lock drop
        do_reset();
        set_p(1, 1'b1, 1'b0, 32'h40, 32'd0, 4'hF);
        dma_lock = 1'b1;
        #1 chk("burst_b1", {30'd0, req_ready}, 32'd2);
        cyc();
        set_p(0, 1'b1, 1'b0, 32'h44, 32'd0, 4'hF);
        for (int i = 0; i < 3; i++) begin
            #1 chk("burst_beat", {30'd0, req_ready}, 32'd2);
            cyc();
        end
        #1 chk("burst_release", {30'd0, req_ready}, 32'd1);
        cyc();
        #1 chk("burst_resume", {30'd0, req_ready}, 32'd2);
        cyc();
        #1 chk("lock_b2", {30'd0, req_ready}, 32'd2);
        cyc();
        req_valid[1] = 1'b0;
        #1 chk("drop_rdy", {30'd0, req_ready}, 32'd2);
        cyc();
        #1 chk("drop_core", {30'd0, req_ready}, 32'd1);
        cyc();
        idle();

        // Partial-byte DMA write and readback
        set_p(1, 1'b1, 1'b1, 32'h08, 32'h1234_5678, 4'b0011);
        cyc();
        idle();
        set_p(1, 1'b1, 1'b0, 32'h08, 32'd0, 4'hF);
        cyc();
        idle();

        // Out-of-range read returns zero
        set_p(0, 1'b1, 1'b0, 32'h0000_1000, 32'd0, 4'hF);
        cyc();
        chk("oor_data", rsp_rdata, 32'd0);
        idle();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < 2; p++) begin
                set_p(p, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 15) == 0) ? 32'h0000_2000 : {24'd0, 6'($urandom_range(0, 63)), 2'b00},
                      $urandom, 4'($urandom_range(0, 15)));
            end
            dma_lock  = 1'($urandom_range(0, 2) != 0);
            mem_ready = 1'($urandom_range(0, 9) > 1);
            cyc();
        end
        idle();
        cyc();

        // Reset while locked with a read presented
        set_p(1, 1'b1, 1'b0, 32'h10, 32'd0, 4'hF);
        dma_lock = 1'b1;
        cyc();
        set_p(0, 1'b1, 1'b0, 32'h10, 32'd0, 4'hF);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        idle();
        cyc();
        set_p(0, 1'b1, 1'b0, 32'h14, 32'd0, 4'hF);
        set_p(1, 1'b1, 1'b0, 32'h18, 32'd0, 4'hF);
        dma_lock = 1'b1;
        #1 chk("post_rst_grant", {30'd0, req_ready}, 32'd1);
        cyc();
        idle();
        cyc();
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
